// File: rtl/timer_multi_if.sv
// Peripheral bus bundle for timer_multi: request strobe, write enable,
// byte address, write data and combinational read data.
interface timer_multi_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input rdata);
  modport slave  (input req, we, addr, wdata, output rdata);
endinterface

// File: rtl/timer_multi.sv
// Multi-channel bus-mapped timer: NUM_CH up-counters sharing one prescaler,
// each with compare value, periodic/one-shot mode and a sticky maskable interrupt.
module timer_multi #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_CH      = 4,
  parameter int PRESC_WIDTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  timer_multi_if.slave      bus,
  output logic [NUM_CH-1:0] ch_irq_o,
  output logic              irq_o
);

  logic [7:0]             off;
  logic                   unused_addr;
  logic                   wr;
  logic                   wr_presc, wr_status, wr_ie;
  logic                   tick;

  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [NUM_CH-1:0]      status_q, status_d;
  logic [NUM_CH-1:0]      ie_q, ie_d;
  logic [NUM_CH-1:0]      en_q, en_d;
  logic [NUM_CH-1:0]      os_q, os_d;
  logic [NUM_CH-1:0]      match_set;
  logic [DATA_WIDTH-1:0]  count_q [NUM_CH];
  logic [DATA_WIDTH-1:0]  count_d [NUM_CH];
  logic [DATA_WIDTH-1:0]  cmp_q   [NUM_CH];
  logic [DATA_WIDTH-1:0]  cmp_d   [NUM_CH];
  logic [DATA_WIDTH-1:0]  rdata_d;

  assign off         = bus.addr[7:0];
  assign unused_addr = ^bus.addr[ADDR_WIDTH-1:8];
  assign wr          = bus.req & bus.we;
  assign wr_presc    = wr && (off == 8'h00);
  assign wr_status   = wr && (off == 8'h04);
  assign wr_ie       = wr && (off == 8'h08);
  assign tick        = (pcnt_q == presc_q);

  // Next-state: count write beats tick, match beats increment, CTRL write beats one-shot disable
  always_comb begin
    presc_d   = wr_presc ? bus.wdata[PRESC_WIDTH-1:0] : presc_q;
    pcnt_d    = (wr_presc || tick) ? '0 : pcnt_q + PRESC_WIDTH'(1);
    ie_d      = wr_ie ? bus.wdata[NUM_CH-1:0] : ie_q;
    en_d      = en_q;
    os_d      = os_q;
    match_set = '0;
    count_d   = count_q;
    cmp_d     = cmp_q;
    for (int n = 0; n < NUM_CH; n++) begin
      if (wr && off[7:4] == 4'(n + 1) && off[3:0] == 4'h4) begin
        count_d[n] = bus.wdata;
      end else if (en_q[n] && tick && count_q[n] == cmp_q[n]) begin
        count_d[n]   = '0;
        match_set[n] = 1'b1;
        if (os_q[n]) en_d[n] = 1'b0;
      end else if (en_q[n] && tick) begin
        count_d[n] = count_q[n] + DATA_WIDTH'(1);
      end
      if (wr && off[7:4] == 4'(n + 1) && off[3:0] == 4'h0) begin
        en_d[n] = bus.wdata[0];
        os_d[n] = bus.wdata[1];
      end
      if (wr && off[7:4] == 4'(n + 1) && off[3:0] == 4'h8) begin
        cmp_d[n] = bus.wdata;
      end
    end
    // A match in the same cycle as its W1C keeps the flag set
    status_d = (status_q & ~(wr_status ? bus.wdata[NUM_CH-1:0] : '0)) | match_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q  <= '0;
      pcnt_q   <= '0;
      status_q <= '0;
      ie_q     <= '0;
      en_q     <= '0;
      os_q     <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        count_q[n] <= '0;
        cmp_q[n]   <= '0;
      end
    end else begin
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      status_q <= status_d;
      ie_q     <= ie_d;
      en_q     <= en_d;
      os_q     <= os_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (bus.req) begin
      if (off == 8'h00) rdata_d[PRESC_WIDTH-1:0] = presc_q;
      if (off == 8'h04) rdata_d[NUM_CH-1:0] = status_q;
      if (off == 8'h08) rdata_d[NUM_CH-1:0] = ie_q;
      for (int n = 0; n < NUM_CH; n++) begin
        if (off[7:4] == 4'(n + 1)) begin
          if (off[3:0] == 4'h0) rdata_d[1:0] = {os_q[n], en_q[n]};
          if (off[3:0] == 4'h4) rdata_d = count_q[n];
          if (off[3:0] == 4'h8) rdata_d = cmp_q[n];
        end
      end
    end
  end

  assign bus.rdata = rdata_d;
  assign ch_irq_o  = status_q & ie_q;
  assign irq_o     = |ch_irq_o;

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: expected values are queued when a check is
// issued and popped against the DUT response sampled in the clock low phase.
module tb_timer_multi;

  logic       clk;
  logic       rst_n;
  logic [3:0] ch_irq;
  logic       irq;

  logic [31:0] exp_q [$];
  string       tag_q [$];
  int          n_cmp;
  int          n_err;

  timer_multi_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  timer_multi #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_CH     (4),
    .PRESC_WIDTH(16)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .ch_irq_o(ch_irq),
    .irq_o   (irq)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", t, obs, e);
    end
  endtask

  task automatic rd(input string tag, input logic [7:0] off, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = {24'h0, off};
    #1;
    chk(bus.rdata);
    bus.req  = 1'b0;
  endtask

  task automatic irqchk(input string tag, input logic ei, input logic [3:0] ech);
    exp_q.push_back({27'h0, ei, ech});
    tag_q.push_back(tag);
    #1;
    chk({27'h0, irq, ch_irq});
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = {24'h0, off};
    bus.wdata = d;
    @(negedge clk);
    bus.req   = 1'b0;
    bus.we    = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;

    // Reset state
    #2;
    exp_q.push_back(32'h0); tag_q.push_back("rst_rdata_idle");
    chk(bus.rdata);
    irqchk("rst_irq", 1'b0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("rst_presc", 8'h00, 32'h0);
    rd("rst_count0", 8'h14, 32'h0);

    // Channel 0 periodic, PRESC=0, CMP=3
    wr(8'h18, 32'd3);
    wr(8'h08, 32'h1);
    wr(8'h10, 32'h1);
    rd("c0_seq0", 8'h14, 32'd0);
    step(1); rd("c0_seq1", 8'h14, 32'd1);
    step(1); rd("c0_seq2", 8'h14, 32'd2);
    step(1); rd("c0_seq3", 8'h14, 32'd3);
    rd("c0_stat_pre", 8'h04, 32'h0);
    step(1); rd("c0_seq4", 8'h14, 32'd0);
    rd("c0_stat_match", 8'h04, 32'h1);
    irqchk("c0_irq_match", 1'b1, 4'h1);
    wr(8'h04, 32'h1);
    rd("c0_w1c", 8'h04, 32'h0);
    irqchk("c0_irq_w1c", 1'b0, 4'h0);
    rd("c0_cnt_after_w1c", 8'h14, 32'd1);
    step(2); rd("c0_cnt3", 8'h14, 32'd3);

    // W1C on the same edge as a match: set wins
    wr(8'h04, 32'h1);
    rd("c0_setwins_stat", 8'h04, 32'h1);
    rd("c0_setwins_cnt", 8'h14, 32'd0);
    irqchk("c0_setwins_irq", 1'b1, 4'h1);
    wr(8'h04, 32'h1);
    irqchk("c0_later_w1c_irq", 1'b0, 4'h0);
    wr(8'h10, 32'h0);
    step(3);
    rd("c0_hold_cnt", 8'h14, 32'd2);
    rd("c0_ctrl_off", 8'h10, 32'h0);

    // Channel 1 one-shot with PRESC=4, CMP=1 (interrupt masked by IE=1)
    wr(8'h28, 32'd1);
    wr(8'h00, 32'd4);
    wr(8'h20, 32'h3);
    rd("presc_rd", 8'h00, 32'd4);
    step(3); rd("c1_cnt_pretick", 8'h24, 32'd0);
    step(1); rd("c1_cnt_tick1", 8'h24, 32'd1);
    step(4); rd("c1_cnt_hold", 8'h24, 32'd1);
    rd("c1_stat_pre", 8'h04, 32'h0);
    step(1); rd("c1_cnt_match", 8'h24, 32'd0);
    rd("c1_stat_match", 8'h04, 32'h2);
    rd("c1_ctrl_en_off", 8'h20, 32'h2);
    irqchk("c1_masked_irq", 1'b0, 4'h0);
    step(10); rd("c1_cnt_stays0", 8'h24, 32'd0);

    // Unmask all channels: pending flag drives irq immediately
    wr(8'h08, 32'hF);
    irqchk("ie_unmask_irq", 1'b1, 4'h2);
    wr(8'h04, 32'hF);
    irqchk("ie_clear_irq", 1'b0, 4'h0);

    // Channel 2 wrap-around: COUNT=0xFFFF_FFFE, CMP=1, PRESC=0
    wr(8'h00, 32'd0);
    wr(8'h34, 32'hFFFF_FFFE);
    wr(8'h38, 32'd1);
    wr(8'h30, 32'h1);
    rd("c2_start", 8'h34, 32'hFFFF_FFFE);
    step(1); rd("c2_ff", 8'h34, 32'hFFFF_FFFF);
    step(1); rd("c2_wrap0", 8'h34, 32'd0);
    step(1); rd("c2_one", 8'h34, 32'd1);
    rd("c2_stat_pre", 8'h04, 32'h0);
    step(1); rd("c2_match_cnt", 8'h34, 32'd0);
    irqchk("c2_match_irq", 1'b1, 4'h4);
    wr(8'h34, 32'd5);
    rd("c2_wr_beats_tick", 8'h34, 32'd5);
    wr(8'h30, 32'h0);
    step(2); rd("c2_disabled", 8'h34, 32'd6);

    // Channel 3 one-shot, CMP=0: CTRL write during match keeps EN
    wr(8'h30 + 8'h10, 32'h3);
    wr(8'h40, 32'h3);
    rd("c3_ctrl_written_wins", 8'h40, 32'h3);
    rd("c3_stat", 8'h04, 32'hC);
    step(1);
    rd("c3_ctrl_oneshot_off", 8'h40, 32'h2);
    rd("c3_cnt", 8'h44, 32'd0);

    // Unmapped offsets
    wr(8'h0C, 32'hFFFF_FFFF);
    rd("unmapped_0c", 8'h0C, 32'h0);
    rd("unmapped_ch4", 8'h50, 32'h0);

    // Asynchronous reset mid-run
    wr(8'h00, 32'd3);
    wr(8'h10, 32'h1);
    step(1);
    irqchk("pre_rst_irq", 1'b1, 4'hC);
    #10;
    rst_n = 1'b0;
    irqchk("async_rst_irq", 1'b0, 4'h0);
    rd("async_rst_presc", 8'h00, 32'h0);
    rd("async_rst_stat", 8'h04, 32'h0);
    rd("async_rst_ie", 8'h08, 32'h0);
    rd("async_rst_cnt2", 8'h34, 32'h0);
    rd("async_rst_0c", 8'h0C, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    rd("post_rst_ctrl0", 8'h10, 32'h0);
    rd("post_rst_cnt0", 8'h14, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
